byron_alu_frontend: RTL and testbench
=====================================

// Module: byron_alu_frontend
// PURPOSE
//  Host-side command front end for the 8-bit ALU: drives the ALU operand/select inputs and reads its result.
//  - Assembles full 8-bit A, 8-bit B and the 3-bit select from nibble commands strobed on the 8 input pins.
//  - Runs the ALU for a programmed number of cycles, then captures Result/Cout.
//  - Presents either the result or a status byte on the 8 output pins.
//  - Sits between the chip-top pins and alu_8bit, replacing the direct 3-bit/2-bit operand pin mapping.
// PARAMETERS
//  SYNC_STAGES  2  synchronizer depth for ui_in, allowed range 2..3
//  EXEC_CYCLES  1  cycles operands are held stable before capture, allowed range 1..15
// PORTS
//  clk         in   1  single clock
//  rst_n       in   1  asynchronous reset, active-low
//  ena         in   1  1 = block runs; 0 = every register holds, except the synchronizer and edge detector
//  ui_in       in   8  [7]=strobe, [6:4]=cmd, [3:0]=data nibble
//  uo_out      out  8  result byte or status byte (selected by view_q)
//  alu_a       out  8  operand A to the ALU (= a_q)
//  alu_b       out  8  operand B to the ALU (= b_q)
//  alu_sel     out  3  operation select to the ALU (= sel_q)
//  alu_result  in   8  ALU result
//  alu_cout    in   1  ALU carry out
// BEHAVIOUR
//  Reset: a_q, b_q, result_q = 8'h00; sel_q = 3'b000; cout_q, done, overrun, view_q = 0; state = IDLE.
//    Consequence: uo_out = 8'h00; alu_* = 0.
//  Input path: all 8 ui_in bits pass through SYNC_STAGES flops, then a prev-strobe flop.
//    - A command fires on the first cycle where sync strobe = 1 and prev = 0 (rising edge).
//    - Latency from the first clk edge sampling ui_in[7] = 1 to the command taking effect: SYNC_STAGES+1 edges.
//    - cmd and data must be stable from 1 cycle before the strobe rises until it falls.
//  Commands (in IDLE):
//    - 000: a_q[3:0] <= data
//    - 001: a_q[7:4] <= data
//    - 010: b_q[3:0] <= data
//    - 011: b_q[7:4] <= data
//    - 100 GO: sel_q <= data[2:0]; done <= 0; -> EXEC
//    - 101: clear overrun
//    - 110 CHAIN: see CONFIGURATION
//    - 111: view_q <= data[0]; clear overrun
//  FSM: IDLE -> (GO) EXEC -> CAPTURE -> IDLE.
//    - EXEC: hold for EXEC_CYCLES cycles, counter counts EXEC_CYCLES-1 down to 0.
//    - CAPTURE: one cycle; result_q <= alu_result, cout_q <= alu_cout, done <= 1.
//    - GO-to-done latency: EXEC_CYCLES+1 cycles after GO takes effect.
//  Busy: busy = (state != IDLE).
//    - A strobe edge while busy drops the command and sets overrun (sticky).
//    - Operands are never modified while busy.
//  uo_out:
//    - view_q = 0: result_q
//    - view_q = 1: {busy, done, cout_q, overrun, 1'b0, sel_q}
//    - Registered-only path; no combinational ui_in -> uo_out path.
//  ena = 0:
//    - FSM, counter and all data registers hold.
//    - Synchronizer and edge detector keep sampling; an edge occurring while ena = 0 is lost, never replayed.
//  Reset mid-operation: immediate return to reset values; an in-flight GO is abandoned and done stays 0.
//  Simultaneous edge and CAPTURE cycle: the command is dropped and overrun is set (CAPTURE counts as busy).
//  Widths: operands 8 bit; no arithmetic in this block apart from the 4-bit exec counter.
// CONFIGURATION
//  BYRON_FE_CHAIN_EN defined:
//    - cmd 110 = CHAIN: a_q <= result_q, sel_q <= data[2:0], done <= 0, -> EXEC.
//    - Gives accumulator-style chaining.
//  Not defined:
//    - cmd 110 is a no-op in IDLE; it still sets overrun if issued while busy.
//    - No extra logic.
// STRUCTURE
//  byron_fe_pkg:
//    - cmd localparams CMD_A_LO..CMD_VIEW
//    - state enum IDLE/EXEC/CAPTURE
//    - status bit positions ST_BUSY = 7, ST_DONE = 6, ST_COUT = 5, ST_OVR = 4
//  Sub-module byron_in_sync: SYNC_STAGES-deep 8-bit synchronizer plus strobe rising-edge pulse.
//  Top: command decode, FSM, counter, output mux.
// TESTING (bench ALU stub: sel 000 = A+B with carry, 001 = A-B)
//  1. Load A = 8'h3C, B = 8'h15, GO sel = 000 -> after EXEC_CYCLES+1: uo_out = 8'h51; status (view 1) = 8'h40.
//  2. A = 8'hF0, B = 8'h20, GO 000 -> uo_out = 8'h10, status = 8'h60 (done, cout).
//  3. GO, then strobe cmd 000 data 4'hF while in EXEC
//     -> a_q unchanged, overrun = 1; cmd 101 -> overrun = 0.
//  4. Assert rst_n = 0 during EXEC -> uo_out = 8'h00, alu_a/alu_b/alu_sel = 0, done = 0 after release.
//  5. ena = 0 across a strobe edge
//     -> command lost, registers unchanged; re-enable without a new edge -> no action.
//  6. With BYRON_FE_CHAIN_EN: result 8'h51, CHAIN sel 000 with B = 8'h15 -> uo_out = 8'h66.
//     Without it: CHAIN is a no-op and uo_out stays 8'h51.

Source files
------------

// File: rtl/byron_fe_pkg.sv
// byron_fe_pkg: command codes, FSM states and status bit positions for the ALU front end
package byron_fe_pkg;
  localparam logic [2:0] CMD_A_LO  = 3'd0;
  localparam logic [2:0] CMD_A_HI  = 3'd1;
  localparam logic [2:0] CMD_B_LO  = 3'd2;
  localparam logic [2:0] CMD_B_HI  = 3'd3;
  localparam logic [2:0] CMD_GO    = 3'd4;
  localparam logic [2:0] CMD_CLR   = 3'd5;
  localparam logic [2:0] CMD_CHAIN = 3'd6;
  localparam logic [2:0] CMD_VIEW  = 3'd7;
  typedef enum logic [1:0] {IDLE, EXEC, CAPTURE} state_t;
  localparam int ST_BUSY = 7;
  localparam int ST_DONE = 6;
  localparam int ST_COUT = 5;
  localparam int ST_OVR  = 4;
endpackage

// File: rtl/byron_fe_if.sv
// byron_fe_if: operand/select/result bus between the front end (master) and alu_8bit (slave)
interface byron_fe_if;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] sel;
  logic [7:0] result;
  logic       cout;
  modport master(output a, b, sel, input result, cout);
  modport slave(input a, b, sel, output result, cout);
endinterface

// File: rtl/byron_in_sync.sv
// byron_in_sync: multi-stage synchronizer for the input pins plus a strobe rising-edge pulse
module byron_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] d,
  output logic [6:0] q,
  output logic       rise
);
  logic [SYNC_STAGES-1:0][7:0] stg;
  logic                        prev;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg  <= '0;
      prev <= 1'b0;
    end else begin
      stg  <= {stg[SYNC_STAGES-2:0], d};
      prev <= stg[SYNC_STAGES-1][7];
    end
  end
  assign q    = stg[SYNC_STAGES-1][6:0];
  assign rise = stg[SYNC_STAGES-1][7] & ~prev;
endmodule

// File: rtl/byron_alu_frontend.sv
// byron_alu_frontend: nibble-command front end that loads operands, runs alu_8bit and reports result/status.
// Defining BYRON_FE_CHAIN_EN turns cmd 110 into CHAIN (A <= result, new select, run again).
module byron_alu_frontend
  import byron_fe_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EXEC_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [7:0]    ui_in,
  output logic [7:0]    uo_out,
  byron_fe_if.master    alu
);
  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);
  logic [6:0] cmd_data;
  logic [2:0] cmd;
  logic [3:0] data;
  logic       rise, busy, fire, start, chain;
  state_t     state, state_d;
  logic [7:0] a_q, b_q, result_q, status;
  logic [2:0] sel_q;
  logic [3:0] cnt;
  logic       cout_q, done, overrun, view_q;
  byron_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ui_in),
    .q    (cmd_data),
    .rise (rise)
  );
  assign cmd  = cmd_data[6:4];
  assign data = cmd_data[3:0];
  assign busy = state != IDLE;
  assign fire = ena & rise & ~busy;
`ifdef BYRON_FE_CHAIN_EN
  assign chain = fire && cmd == CMD_CHAIN;
`else
  assign chain = 1'b0;
`endif
  assign start = (fire && cmd == CMD_GO) || chain;
  always_comb begin
    state_d = state == IDLE ? (start ? EXEC : IDLE) :
              state == EXEC ? (cnt == 4'd0 ? CAPTURE : EXEC) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else if (ena) state <= state_d;
  end
  // CAPTURE is still busy, so an edge landing on it is dropped as an overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      result_q <= 8'h00;
      sel_q    <= 3'b000;
      cout_q   <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      view_q   <= 1'b0;
      cnt      <= 4'd0;
    end else if (ena) begin
      if (rise && busy) overrun <= 1'b1;
      if (fire) begin
        case (cmd)
          CMD_A_LO: a_q[3:0] <= data;
          CMD_A_HI: a_q[7:4] <= data;
          CMD_B_LO: b_q[3:0] <= data;
          CMD_B_HI: b_q[7:4] <= data;
          CMD_CLR:  overrun <= 1'b0;
          CMD_VIEW: begin
            view_q  <= data[0];
            overrun <= 1'b0;
          end
          default: ;
        endcase
      end
      if (start) begin
        sel_q <= data[2:0];
        done  <= 1'b0;
        cnt   <= CNT_INIT;
      end
`ifdef BYRON_FE_CHAIN_EN
      if (chain) a_q <= result_q;
`endif
      if (state == EXEC && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (state == CAPTURE) begin
        result_q <= alu.result;
        cout_q   <= alu.cout;
        done     <= 1'b1;
      end
    end
  end
  always_comb begin
    status          = 8'h00;
    status[ST_BUSY] = busy;
    status[ST_DONE] = done;
    status[ST_COUT] = cout_q;
    status[ST_OVR]  = overrun;
    status[2:0]     = sel_q;
  end
  assign uo_out  = view_q ? status : result_q;
  assign alu.a   = a_q;
  assign alu.b   = b_q;
  assign alu.sel = sel_q;
endmodule

// File: tb/tb_byron_alu_frontend.sv
// tb_byron_alu_frontend: scoreboarded directed bench for the ALU front end with a small add/sub ALU stub
module tb_byron_alu_frontend;
  import byron_fe_pkg::*;
  localparam int SYNC = 2;
  localparam int EXEC = 6;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out;
  logic [8:0] alu_sum;
  logic       mon_prev = 1'b0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  byron_fe_if bus();
  byron_alu_frontend #(.SYNC_STAGES(SYNC), .EXEC_CYCLES(EXEC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .ui_in (ui_in),
    .uo_out(uo_out),
    .alu   (bus)
  );
  always #5 clk = ~clk;
  assign alu_sum    = bus.sel == 3'd1 ? {1'b0, bus.a} - {1'b0, bus.b} : {1'b0, bus.a} + {1'b0, bus.b};
  assign bus.result = alu_sum[7:0];
  assign bus.cout   = alu_sum[8];
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h want %02h", name, act, exp);
    end
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (dut.done && !mon_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got uo_out %02h with no pending expectation", uo_out);
        end else check("done_output", uo_out, exp_q.pop_front());
      end
      mon_prev = dut.done;
    end
  end
  task automatic send(input logic [2:0] c, input logic [3:0] d);
    @(negedge clk) ui_in = {1'b0, c, d};
    @(negedge clk) ui_in[7] = 1'b1;
    @(negedge clk);
    @(negedge clk) ui_in[7] = 1'b0;
    @(negedge clk);
  endtask
  task automatic run(input logic [2:0] c, input logic [2:0] s, input logic [7:0] exp);
    int   n;
    logic prev, seen;
    exp_q.push_back(exp);
    @(negedge clk) ui_in = {1'b0, c, 1'b0, s};
    @(negedge clk) ui_in[7] = 1'b1;
    prev = 1'b1;
    seen = 1'b0;
    n = 0;
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 2) ui_in[7] = 1'b0;
      seen = dut.done && !prev;
      prev = dut.done;
    end
    checks++;
    if (!seen || n != SYNC + EXEC + 2) begin
      failures++;
      $display("FAIL go_latency: got %0d cycles (seen=%0d) want %0d", n, seen, SYNC + EXEC + 2);
    end
  endtask
  task automatic wait_done();
    int n = 0;
    while (!dut.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!dut.done) begin
      failures++;
      $display("FAIL done_timeout: got done=0 after %0d cycles want done=1", n);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before 100000ns");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_uo_out", uo_out, 8'h00);
    check("rst_alu_a", bus.a, 8'h00);
    check("rst_alu_b", bus.b, 8'h00);
    check("rst_alu_sel", {5'b0, bus.sel}, 8'h00);
    rst_n = 1'b1;
    send(CMD_A_LO, 4'hC);
    send(CMD_A_HI, 4'h3);
    send(CMD_B_LO, 4'h5);
    send(CMD_B_HI, 4'h1);
    check("load_a", bus.a, 8'h3C);
    check("load_b", bus.b, 8'h15);
    run(CMD_GO, 3'd0, 8'h51);
    send(CMD_VIEW, 4'h1);
    check("status_add", uo_out, 8'h40);
    send(CMD_VIEW, 4'h0);
    run(CMD_GO, 3'd1, 8'h27);
    send(CMD_VIEW, 4'h1);
    check("status_sub", uo_out, 8'h41);
    send(CMD_VIEW, 4'h0);
    send(CMD_A_LO, 4'h0);
    send(CMD_A_HI, 4'hF);
    send(CMD_B_LO, 4'h0);
    send(CMD_B_HI, 4'h2);
    run(CMD_GO, 3'd0, 8'h10);
    send(CMD_VIEW, 4'h1);
    check("status_cout", uo_out, 8'h60);
    exp_q.push_back(8'h70);
    send(CMD_GO, 4'h0);
    send(CMD_A_LO, 4'hF);
    check("busy_a_kept", bus.a, 8'hF0);
    check("busy_b_kept", bus.b, 8'h20);
    wait_done();
    send(CMD_CLR, 4'h0);
    check("overrun_clr", uo_out, 8'h60);
    send(CMD_VIEW, 4'h0);
    check("view_result", uo_out, 8'h10);
    send(CMD_GO, 4'h1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("midrst_uo_out", uo_out, 8'h00);
    check("midrst_alu_a", bus.a, 8'h00);
    check("midrst_alu_b", bus.b, 8'h00);
    check("midrst_alu_sel", {5'b0, bus.sel}, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    send(CMD_VIEW, 4'h1);
    check("midrst_status", uo_out, 8'h00);
    ena = 1'b0;
    send(CMD_A_LO, 4'h7);
    repeat (2) @(negedge clk);
    ena = 1'b1;
    repeat (6) @(negedge clk);
    check("ena_lost_a", bus.a, 8'h00);
    check("ena_lost_status", uo_out, 8'h00);
    send(CMD_A_LO, 4'h7);
    check("ena_back_a", bus.a, 8'h07);
    send(CMD_A_LO, 4'hC);
    send(CMD_A_HI, 4'h3);
    send(CMD_B_LO, 4'h5);
    send(CMD_B_HI, 4'h1);
    send(CMD_VIEW, 4'h0);
    run(CMD_GO, 3'd0, 8'h51);
`ifdef BYRON_FE_CHAIN_EN
    run(CMD_CHAIN, 3'd0, 8'h66);
    check("chain_a", bus.a, 8'h51);
`else
    send(CMD_CHAIN, 4'h0);
    repeat (12) @(negedge clk);
    check("chain_noop_out", uo_out, 8'h51);
    check("chain_noop_a", bus.a, 8'h3C);
`endif
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_results: got %0d left want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
